divisor_clock: RTL and testbench
================================

Name: divisor_clock

Overview:
- Programmable clock divider that sits directly upstream of the LED blink stage.
- Produces the slow square wave that drives the blinker's clock input, plus a one-cycle tick on every rising edge of that wave.
- Half-period is runtime-loadable; a new value takes effect only at a toggle boundary, so the output never glitches.

Parameters:
- WIDTH, 16, width of the divisor and counter.
- DIV_DEFAULT, 4, half-period in input clock cycles after reset; must be 1..2^WIDTH-1.

Ports:
- clk_in1  input  1  system clock; all logic on rising edge.
- rst_in1  input  1  asynchronous, active-high reset.
- en_in1  input  1  run enable; low freezes the divider.
- div_in1  input  WIDTH  requested half-period in clk_in1 cycles.
- load_in1  input  1  one-cycle strobe that captures div_in1.
- load_ack_out1  output  1  one-cycle pulse when a captured divisor becomes active.
- clk_out1  output  1  divided clock (to the blinker clock input); full period = 2*H cycles.
- tick_out1  output  1  one-cycle pulse in the cycle clk_out1 goes 0->1.

Behaviour:
- Registers:
  - H: active half-period.
  - cnt: WIDTH-bit counter.
  - P: pending divisor, with pending flag pf.
  - All outputs are registered.
- Reset (asynchronous, any time, including mid-period or mid-load):
  - H=DIV_DEFAULT, cnt=0, pf=0, P=0.
  - clk_out1=0, tick_out1=0, load_ack_out1=0.
- States:
  - STOP: en_in1=0.
  - RUN: en_in1=1.
  - Re-evaluated every cycle from en_in1 (no extra state).
- RUN, cnt != H-1: cnt<=cnt+1. clk_out1 holds. tick=0.
- RUN, cnt == H-1 (boundary):
  - cnt<=0 and clk_out1<=~clk_out1.
  - tick_out1<=1 only if clk_out1 was 0.
  - If pf=1: H<=P, pf<=0, load_ack_out1<=1 in the same cycle.
- STOP:
  - cnt and clk_out1 hold; tick_out1=0.
  - If pf=1: H<=P, cnt<=0, pf<=0, load_ack_out1<=1.
- Load:
  - load_in1=1 captures P<=(div_in1==0 ? 1 : div_in1) and sets pf<=1.
  - A captured value is applied no earlier than the next cycle.
  - A load coinciding with a boundary applies the older pending value (if any) at that boundary; the new value stays pending.
  - A second load before application overwrites P; only one ack is issued, for the latest value.
- Latency:
  - After reset with en_in1=1, clk_out1 first rises on the DIV_DEFAULT-th enabled rising edge (cnt 0..H-1).
  - Steady state: high for H cycles, low for H cycles.
- Boundaries:
  - H=1: clk_out1 toggles every cycle; tick every 2 cycles.
  - H=2^WIDTH-1: cnt reaches H-1 without overflow.
  - en_in1 falling mid-period: the phase is frozen and resumes exactly where it stopped.
- tick_out1 and load_ack_out1 are never high for two consecutive cycles, except tick when H=1 is ruled out (tick is at most every 2 cycles).

Optional Feature:
- Macro: DIVISOR_CLOCK_TICK_COUNT_EN.
- Defined:
  - Adds output tick_count_out1 (WIDTH bits), reset to 0.
  - Increments in the same cycle tick_out1=1; wraps from 2^WIDTH-1 to 0.
  - Holds during STOP.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset release, en=1, defaults (DIV_DEFAULT=4) -> clk_out1 rises at enabled edge 4, falls at edge 8, period 8; tick_out1 high only at edges 4, 12, 20.
- Load div_in1=2 at edge 5 -> ack at edge 8 (boundary); afterwards high 2 / low 2 cycles; no runt pulse.
- Load div_in1=0 -> treated as 1; clk_out1 toggles every cycle after ack; tick every 2 cycles.
- en=0 for 10 cycles mid-period (cnt=2) -> clk_out1 and cnt frozen; resumes and toggles 2 cycles after en returns. A load during STOP acks the next cycle and cnt restarts at 0.
- Two loads (6 then 3) before a boundary -> single ack; H=3 is active.
- Assert rst_in1 asynchronously mid-high-phase, between clock edges -> clk_out1, tick, ack and cnt all 0 immediately, and H=4. With the macro defined: tick_count_out1 is 0 after reset and reads 3 after three ticks.

Source files
------------

// File: rtl/divisor_clock_if.sv
// divisor_clock_if: control/status bundle between the divider and its user.
// tick_count_out1 exists only when DIVISOR_CLOCK_TICK_COUNT_EN is defined.
interface divisor_clock_if #(parameter int WIDTH = 16);
  logic             en_in1;
  logic [WIDTH-1:0] div_in1;
  logic             load_in1;
  logic             load_ack_out1;
  logic             clk_out1;
  logic             tick_out1;
`ifdef DIVISOR_CLOCK_TICK_COUNT_EN
  logic [WIDTH-1:0] tick_count_out1;
  modport master (output en_in1, div_in1, load_in1, input load_ack_out1, clk_out1, tick_out1, tick_count_out1);
  modport slave (input en_in1, div_in1, load_in1, output load_ack_out1, clk_out1, tick_out1, tick_count_out1);
`else
  modport master (output en_in1, div_in1, load_in1, input load_ack_out1, clk_out1, tick_out1);
  modport slave (input en_in1, div_in1, load_in1, output load_ack_out1, clk_out1, tick_out1);
`endif
endinterface

// File: rtl/divisor_clock.sv
// divisor_clock: glitch-free programmable clock divider with rising-edge tick.
// Optional rising-edge counter enabled by DIVISOR_CLOCK_TICK_COUNT_EN.
module divisor_clock #(
  parameter int WIDTH = 16,
  parameter int DIV_DEFAULT = 4
) (
  input logic clk_in1,
  input logic rst_in1,
  divisor_clock_if.slave bus
);
  logic [WIDTH-1:0] h, cnt, p;
  logic pf;
  wire boundary = cnt == h - WIDTH'(1);
  wire [WIDTH-1:0] div_sat = (bus.div_in1 == '0) ? WIDTH'(1) : bus.div_in1;
  always_ff @(posedge clk_in1 or posedge rst_in1) begin
    if (rst_in1) begin
      h <= WIDTH'(DIV_DEFAULT);
      cnt <= '0;
      p <= '0;
      pf <= 1'b0;
      bus.clk_out1 <= 1'b0;
      bus.tick_out1 <= 1'b0;
      bus.load_ack_out1 <= 1'b0;
`ifdef DIVISOR_CLOCK_TICK_COUNT_EN
      bus.tick_count_out1 <= '0;
`endif
    end else begin
      bus.tick_out1 <= 1'b0;
      bus.load_ack_out1 <= 1'b0;
      if (bus.load_in1) begin
        p <= div_sat;
        pf <= 1'b1;
      end
      // A load in the same cycle as an apply keeps the new value pending
      if (bus.en_in1) begin
        if (boundary) begin
          cnt <= '0;
          bus.clk_out1 <= ~bus.clk_out1;
          bus.tick_out1 <= ~bus.clk_out1;
`ifdef DIVISOR_CLOCK_TICK_COUNT_EN
          if (!bus.clk_out1) bus.tick_count_out1 <= bus.tick_count_out1 + WIDTH'(1);
`endif
          if (pf) begin
            h <= p;
            bus.load_ack_out1 <= 1'b1;
            if (!bus.load_in1) pf <= 1'b0;
          end
        end else begin
          cnt <= cnt + WIDTH'(1);
        end
      end else if (pf) begin
        h <= p;
        cnt <= '0;
        bus.load_ack_out1 <= 1'b1;
        if (!bus.load_in1) pf <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_divisor_clock.sv
// tb_divisor_clock: directed self-checking bench for divisor_clock.
module tb_divisor_clock;
  logic clk_in1 = 1'b0;
  logic rst_in1 = 1'b1;
  int checks = 0;
  int failures = 0;
  divisor_clock_if #(.WIDTH(16)) bus ();
  divisor_clock #(.WIDTH(16), .DIV_DEFAULT(4)) dut (.clk_in1(clk_in1), .rst_in1(rst_in1), .bus(bus));
  always #5 clk_in1 = ~clk_in1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic ec, input logic et, input logic ea);
    @(posedge clk_in1);
    #1;
    chk({tag, ".clk"}, 32'(bus.clk_out1), 32'(ec));
    chk({tag, ".tick"}, 32'(bus.tick_out1), 32'(et));
    chk({tag, ".ack"}, 32'(bus.load_ack_out1), 32'(ea));
  endtask
  task automatic do_reset();
    rst_in1 = 1'b1;
    @(posedge clk_in1);
    #1;
    rst_in1 = 1'b0;
  endtask
  initial begin
    bus.en_in1 = 1'b1;
    bus.div_in1 = '0;
    bus.load_in1 = 1'b0;
    do_reset();
    chk("rst.clk", 32'(bus.clk_out1), 0);
    chk("rst.cnt", 32'(dut.cnt), 0);
    chk("rst.h", 32'(dut.h), 4);
`ifdef DIVISOR_CLOCK_TICK_COUNT_EN
    chk("rst.tcount", 32'(bus.tick_count_out1), 0);
`endif
    // Default H=4: rises at edge 4, falls at 8, ticks at 4, 12, 20
    for (int e = 1; e <= 20; e++) step("dflt", 1'((e / 4) % 2), e % 8 == 4, 1'b0);
`ifdef DIVISOR_CLOCK_TICK_COUNT_EN
    chk("tcount3", 32'(bus.tick_count_out1), 3);
`endif
    do_reset();
    step("b1", 0, 0, 0);
    step("b2", 0, 0, 0);
    step("b3", 0, 0, 0);
    step("b4", 1, 1, 0);
    bus.div_in1 = 16'd2;
    bus.load_in1 = 1'b1;
    step("b5", 1, 0, 0);
    bus.load_in1 = 1'b0;
    step("b6", 1, 0, 0);
    step("b7", 1, 0, 0);
    step("b8", 0, 0, 1);
    step("b9", 0, 0, 0);
    step("b10", 1, 1, 0);
    step("b11", 1, 0, 0);
    step("b12", 0, 0, 0);
    step("b13", 0, 0, 0);
    step("b14", 1, 1, 0);
    bus.div_in1 = 16'd0;
    bus.load_in1 = 1'b1;
    step("c15", 1, 0, 0);
    bus.load_in1 = 1'b0;
    step("c16", 0, 0, 1);
    step("c17", 1, 1, 0);
    step("c18", 0, 0, 0);
    step("c19", 1, 1, 0);
    step("c20", 0, 0, 0);
    bus.div_in1 = 16'd4;
    bus.load_in1 = 1'b1;
    step("d21", 1, 1, 0);
    bus.load_in1 = 1'b0;
    step("d22", 0, 0, 1);
    step("d23", 0, 0, 0);
    step("d24", 0, 0, 0);
    chk("d.cnt2", 32'(dut.cnt), 2);
    bus.en_in1 = 1'b0;
    for (int i = 0; i < 10; i++) step("dstop", 0, 0, 0);
    chk("d.frozen", 32'(dut.cnt), 2);
    bus.en_in1 = 1'b1;
    step("dres1", 0, 0, 0);
    step("dres2", 1, 1, 0);
    bus.en_in1 = 1'b0;
    bus.div_in1 = 16'd5;
    bus.load_in1 = 1'b1;
    step("ds1", 1, 0, 0);
    bus.load_in1 = 1'b0;
    step("ds2", 1, 0, 1);
    chk("ds.cnt0", 32'(dut.cnt), 0);
    bus.en_in1 = 1'b1;
    for (int i = 0; i < 4; i++) step("ds.run", 1, 0, 0);
    step("ds.fall", 0, 0, 0);
    bus.div_in1 = 16'd6;
    bus.load_in1 = 1'b1;
    step("e1", 0, 0, 0);
    bus.div_in1 = 16'd3;
    step("e2", 0, 0, 0);
    bus.load_in1 = 1'b0;
    step("e3", 0, 0, 0);
    step("e4", 0, 0, 0);
    step("e5", 1, 1, 1);
    step("e6", 1, 0, 0);
    step("e7", 1, 0, 0);
    step("e8", 0, 0, 0);
    step("e9", 0, 0, 0);
    step("e10", 0, 0, 0);
    step("e11", 1, 1, 0);
    chk("e.h3", 32'(dut.h), 3);
    #2;
    rst_in1 = 1'b1;
    #1;
    chk("arst.clk", 32'(bus.clk_out1), 0);
    chk("arst.tick", 32'(bus.tick_out1), 0);
    chk("arst.ack", 32'(bus.load_ack_out1), 0);
    chk("arst.cnt", 32'(dut.cnt), 0);
    chk("arst.h", 32'(dut.h), 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
